// File: rtl/reg_transfer_controller.sv
// Multi-cycle control FSM for the 16-bit CPU datapath: latches a 9-bit
// instruction in T0, then sequences register/ALU/bus enables through T1..T3.
//
// state | meaning
// T0    | fetch: ir_in follows run, capture instr when run=1
// T1    | mv/mvi/NOP finish here; add/sub drive rx into A
// T2    | add/sub: drive ry, load G with A +/- bus
// T3    | add/sub: G drives bus into rx, done
module reg_transfer_controller #(
    parameter int OP_W      = 3,
    parameter int REG_SEL_W = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            run,
    input  logic [OP_W+2*REG_SEL_W-1:0]     instr,
    output logic                            ir_in,
    output logic [(2**REG_SEL_W)-1:0]       r_in,
    output logic [(2**REG_SEL_W)-1:0]       r_out,
    output logic                            a_in,
    output logic                            g_in,
    output logic                            g_out,
    output logic                            din_out,
    output logic                            addsub,
    output logic                            done
);

    localparam int NREG = 2**REG_SEL_W;
    localparam int IR_W = OP_W + 2*REG_SEL_W;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [OP_W-1:0] OP_MV  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MVI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);

    logic [1:0]           r_step;
    logic [IR_W-1:0]      r_ir;

    logic [OP_W-1:0]      w_op;
    logic [REG_SEL_W-1:0] w_rx;
    logic [REG_SEL_W-1:0] w_ry;
    logic [NREG-1:0]      w_rx_oh;
    logic [NREG-1:0]      w_ry_oh;
    logic                 w_is_arith;

    assign w_op       = r_ir[IR_W-1 -: OP_W];
    assign w_rx       = r_ir[2*REG_SEL_W-1 -: REG_SEL_W];
    assign w_ry       = r_ir[REG_SEL_W-1:0];
    assign w_rx_oh    = NREG'(1) << w_rx;
    assign w_ry_oh    = NREG'(1) << w_ry;
    assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            case (r_step)
                T0: begin
                    if (run) begin
                        r_ir   <= instr;
                        r_step <= T1;
                    end
                end
                T1:      r_step <= w_is_arith ? T2 : T0;
                // Non-arith IR in T2 cannot happen normally; bail to fetch.
                T2:      r_step <= w_is_arith ? T3 : T0;
                T3:      r_step <= T0;
                default: r_step <= T0;
            endcase
        end
    end

    always_comb begin
        ir_in   = 1'b0;
        r_in    = '0;
        r_out   = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        if (resetn) begin
            case (r_step)
                T0: ir_in = run;
                T1: begin
                    case (w_op)
                        OP_MV: begin
                            r_out = w_ry_oh;
                            r_in  = w_rx_oh;
                            done  = 1'b1;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            r_in    = w_rx_oh;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            r_out = w_rx_oh;
                            a_in  = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    if (w_is_arith) begin
                        r_out  = w_ry_oh;
                        g_in   = 1'b1;
                        addsub = (w_op == OP_SUB);
                    end
                end
                T3: begin
                    if (w_is_arith) begin
                        g_out = 1'b1;
                        r_in  = w_rx_oh;
                        done  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_transfer_controller.sv
// Self-checking bench for reg_transfer_controller: directed scenarios plus
// random run/instr/reset traffic checked against a per-instruction schedule model.
module tb_reg_transfer_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic [8:0] instr;
    logic       ir_in;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       din_out;
    logic       addsub;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    // Pending per-cycle expected output words of the instruction in flight.
    logic [22:0] sched_q[$];
    logic        prev_done = 1'b0;

    reg_transfer_controller dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .instr   (instr),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .r_out   (r_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .din_out (din_out),
        .addsub  (addsub),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input logic [2:0] idx);
        logic [7:0] one;
        one = 8'd1;
        return one << idx;
    endfunction

    function automatic logic [22:0] mk(input logic ir, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic a,
                                       input logic gi, input logic go,
                                       input logic din, input logic as,
                                       input logic dn);
        return {ir, rin, rout, a, gi, go, din, as, dn};
    endfunction

    function automatic logic [22:0] cur_out();
        return {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, addsub, done};
    endfunction

    task automatic push_sched(input logic [8:0] ins);
        logic [2:0] op, rx, ry;
        op = ins[8:6];
        rx = ins[5:3];
        ry = ins[2:0];
        case (op)
            3'd0: sched_q.push_back(mk(0, oh(rx), oh(ry), 0, 0, 0, 0, 0, 1));
            3'd1: sched_q.push_back(mk(0, oh(rx), 8'h00, 0, 0, 0, 1, 0, 1));
            3'd2, 3'd3: begin
                sched_q.push_back(mk(0, 8'h00, oh(rx), 1, 0, 0, 0, 0, 0));
                sched_q.push_back(mk(0, 8'h00, oh(ry), 0, 1, 0, 0, op == 3'd3, 0));
                sched_q.push_back(mk(0, oh(rx), 8'h00, 0, 0, 1, 0, 0, 1));
            end
            default: sched_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    function automatic logic [22:0] model_expected();
        if (!resetn)              return 23'd0;
        if (sched_q.size() != 0)  return sched_q[0];
        return {run, 22'd0};
    endfunction

    always @(posedge clk) begin
        if (!resetn)                 sched_q.delete();
        else if (sched_q.size() != 0) void'(sched_q.pop_front());
        else if (run)                push_sched(instr);
    end

    always @(negedge clk) begin
        logic [22:0] exp_v, act_v;
        exp_v = model_expected();
        act_v = cur_out();
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs t=%0t act=%h exp=%h", $time, act_v, exp_v);
        end
        n_chk++;
        if ($countones({r_out, g_out, din_out}) > 1) begin
            n_fail++;
            $display("FAIL bus_drivers t=%0t r_out=%h g_out=%b din_out=%b req=at most one",
                     $time, r_out, g_out, din_out);
        end
        n_chk++;
        if ($countones(r_in) > 1 || $countones(r_out) > 1) begin
            n_fail++;
            $display("FAIL onehot t=%0t r_in=%h r_out=%h req=zero/one-hot", $time, r_in, r_out);
        end
        n_chk++;
        if (done && prev_done) begin
            n_fail++;
            $display("FAIL done_pulse t=%0t done high 2 cycles req=1 cycle", $time);
        end
        prev_done = done;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        run    = 1'b1;
        instr  = 9'd0;

        // reset with run high: everything quiet
        @(negedge clk);
        chk("reset_all0_a", 32'(cur_out()), 32'd0);
        cyc();
        @(negedge clk);
        chk("reset_all0_b", 32'(cur_out()), 32'd0);
        cyc();
        resetn = 1'b1;
        @(negedge clk);
        chk("release_ir_in", 32'(ir_in), 32'd1);
        cyc();
        run = 1'b0;
        @(negedge clk);
        chk("mv_r0_r0_rout", 32'(r_out), 32'h01);
        chk("mv_r0_r0_rin", 32'(r_in), 32'h01);
        cyc();

        // mvi r2
        instr = 9'b001_010_000;
        run   = 1'b1;
        cyc();
        run = 1'b0;
        @(negedge clk);
        chk("mvi_din_out", 32'(din_out), 32'd1);
        chk("mvi_r_in", 32'(r_in), 32'h04);
        chk("mvi_done", 32'(done), 32'd1);
        cyc();
        @(negedge clk);
        chk("mvi_after_all0", 32'(cur_out()), 32'd0);
        cyc();

        // mv r7,r1
        instr = 9'b000_111_001;
        run   = 1'b1;
        cyc();
        run = 1'b0;
        @(negedge clk);
        chk("mv_r_out", 32'(r_out), 32'h02);
        chk("mv_r_in", 32'(r_in), 32'h80);
        chk("mv_done", 32'(done), 32'd1);
        cyc();

        // sub then add r1,r6; instr scrambled and run pulsed mid-instruction
        for (int k = 0; k < 2; k++) begin
            logic [2:0] op;
            op    = (k == 0) ? 3'd3 : 3'd2;
            instr = {op, 3'd1, 3'd6};
            run   = 1'b1;
            cyc();
            run   = 1'b0;
            instr = 9'($urandom);
            @(negedge clk);
            chk("arith_t1_r_out", 32'(r_out), 32'h02);
            chk("arith_t1_a_in", 32'(a_in), 32'd1);
            chk("arith_t1_done", 32'(done), 32'd0);
            cyc();
            run = 1'b1;
            @(negedge clk);
            chk("arith_t2_r_out", 32'(r_out), 32'h40);
            chk("arith_t2_g_in", 32'(g_in), 32'd1);
            chk("arith_t2_addsub", 32'(addsub), (op == 3'd3) ? 32'd1 : 32'd0);
            chk("arith_t2_ir_in", 32'(ir_in), 32'd0);
            cyc();
            run = 1'b0;
            @(negedge clk);
            chk("arith_t3_g_out", 32'(g_out), 32'd1);
            chk("arith_t3_r_in", 32'(r_in), 32'h02);
            chk("arith_t3_done", 32'(done), 32'd1);
            cyc();
        end

        // abort an add in T2, then a mv runs cleanly
        instr = 9'b010_011_100;
        run   = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_all0", 32'(cur_out()), 32'd0);
        cyc();
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_next_all0", 32'(cur_out()), 32'd0);
        cyc();
        instr = 9'b000_000_101;
        run   = 1'b1;
        cyc();
        run = 1'b0;
        @(negedge clk);
        chk("post_abort_r_out", 32'(r_out), 32'h20);
        chk("post_abort_r_in", 32'(r_in), 32'h01);
        chk("post_abort_done", 32'(done), 32'd1);
        cyc();

        // run held high: mvi, add, NOP back to back
        instr = 9'b001_100_000;
        run   = 1'b1;
        cyc();
        instr = 9'b010_101_110;
        @(negedge clk);
        chk("b2b_mvi_r_in", 32'(r_in), 32'h10);
        chk("b2b_mvi_done", 32'(done), 32'd1);
        cyc();
        @(negedge clk);
        chk("b2b_fetch_ir_in", 32'(ir_in), 32'd1);
        cyc();
        instr = 9'b101_011_010;
        cyc();
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_r_in", 32'(r_in), 32'h00);
        chk("nop_r_out", 32'(r_out), 32'h00);
        cyc();
        run = 1'b0;
        cyc();

        // random traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 39) != 0);
            run    = ($urandom_range(0, 3) != 0);
            instr  = 9'($urandom);
            cyc();
        end
        resetn = 1'b1;
        run    = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
